// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, forwarding and memory-freeze controller
// Drives en/clear for every inter-stage register and the E-stage forwarding selects.
module hazard_ctrl #(
    parameter int REGW    = 5,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    input  logic [REGW-1:0] rs1E,
    input  logic [REGW-1:0] rs2E,
    input  logic [REGW-1:0] rdE,
    input  logic [REGW-1:0] rdM,
    input  logic [REGW-1:0] rdW,
    input  logic            regwriteE,
    input  logic            regwriteM,
    input  logic            regwriteW,
    input  logic            memreadE,
    input  logic            branch_takenE,
    input  logic            mem_req,
    input  logic            mem_ready,
    output logic            enF,
    output logic            enD,
    output logic            enE,
    output logic            enM,
    output logic            enW,
    output logic            clearD,
    output logic            clearE,
    output logic [1:0]      forwardAE,
    output logic [1:0]      forwardBE,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_ERR     = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic          err_n;
    logic          freeze;
    logic          lwstall;
    logic          stall_evt;

    assign freeze  = mem_req && !mem_ready && (state != S_ERR);
    assign lwstall = memreadE && regwriteE && (rdE != '0) &&
                     ((rdE == rs1D) || (rdE == rs2D));
    // A branch squashes the load-use bubble, so it does not count as a stall.
    assign stall_evt = (state == S_ERR) || freeze || (lwstall && !branch_takenE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            mem_err  <= err_n;
            if (stall_evt && (stall_cnt != {CNTW{1'b1}}))
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

    always_comb begin
        state_n = state;
        wait_n  = wait_cnt;
        err_n   = mem_err;
        case (state)
            S_RUN: begin
                if (freeze) begin
                    state_n = S_MEMWAIT;
                    wait_n  = WW'(1);
                end
            end
            S_MEMWAIT: begin
                if (mem_ready) begin
                    state_n = S_RUN;
                    wait_n  = '0;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    state_n = S_ERR;
                    err_n   = 1'b1;
                end else begin
                    wait_n = wait_cnt + WW'(1);
                end
            end
            S_ERR:   state_n = S_ERR;
            default: state_n = S_RUN;
        endcase
    end

    always_comb begin
        enF    = 1'b1;
        enD    = 1'b1;
        enE    = 1'b1;
        enM    = 1'b1;
        enW    = 1'b1;
        clearD = 1'b0;
        clearE = 1'b0;
        if (reset) begin
            if ((state == S_ERR) || freeze) begin
                enF = 1'b0;
                enD = 1'b0;
                enE = 1'b0;
                enM = 1'b0;
                enW = 1'b0;
            end else if (branch_takenE) begin
                clearD = 1'b1;
                clearE = 1'b1;
            end else if (lwstall) begin
                // Hold F/D, inject a bubble into E; clearE only acts with enE=1.
                enF    = 1'b0;
                enD    = 1'b0;
                clearE = 1'b1;
            end
        end
    end

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (reset) begin
            if (regwriteM && (rdM != '0) && (rdM == rs1E))      forwardAE = 2'b10;
            else if (regwriteW && (rdW != '0) && (rdW == rs1E)) forwardAE = 2'b01;
            if (regwriteM && (rdM != '0) && (rdM == rs2E))      forwardBE = 2'b10;
            else if (regwriteW && (rdW != '0) && (rdW == rs2E)) forwardBE = 2'b01;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Directed scenarios plus randomized traffic against an access-level reference model.
module tb_hazard_ctrl;

    localparam int REGW    = 5;
    localparam int TIMEOUT = 16;
    localparam int CNTW    = 4;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [REGW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic            regwriteE, regwriteM, regwriteW, memreadE, branch_takenE;
    logic            mem_req, mem_ready;
    logic            enF, enD, enE, enM, enW, clearD, clearE;
    logic [1:0]      forwardAE, forwardBE;
    logic            mem_err;
    logic [CNTW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state: one outstanding access, counted in not-ready cycles.
    bit m_active;
    int m_low;
    bit m_err;
    int m_cnt;

    hazard_ctrl #(.REGW(REGW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memreadE(memreadE), .branch_takenE(branch_takenE),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .enF(enF), .enD(enD), .enE(enE), .enM(enM), .enW(enW),
        .clearD(clearD), .clearE(clearE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    wire [15:0] dut_vec = {enF, enD, enE, enM, enW, clearD, clearE,
                           forwardAE, forwardBE, mem_err, stall_cnt};
    wire [4:0]  en_vec  = {enF, enD, enE, enM, enW};

    function automatic bit exp_lw();
        return memreadE && regwriteE && (rdE != 0) && ((rdE == rs1D) || (rdE == rs2D));
    endfunction

    function automatic bit exp_freeze();
        return !m_err && mem_req && !mem_ready;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [REGW-1:0] rs);
        if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [15:0] exp_vec();
        logic [4:0] en;
        logic       cd, ce;
        if (!reset) return {5'h1f, 2'b00, 2'b00, 2'b00, 1'b0, 4'h0};
        en = 5'h1f; cd = 1'b0; ce = 1'b0;
        if (m_err || exp_freeze()) en = 5'h00;
        else if (branch_takenE) begin cd = 1'b1; ce = 1'b1; end
        else if (exp_lw()) begin en = 5'b00111; ce = 1'b1; end
        return {en, cd, ce, exp_fwd(rs1E), exp_fwd(rs2E), m_err, 4'(m_cnt)};
    endfunction

    task automatic model_step();
        bit stalled;
        stalled = m_err || exp_freeze() || (exp_lw() && !branch_takenE);
        if (stalled && m_cnt < CMAX) m_cnt++;
        if (!m_err) begin
            if (m_active) begin
                if (mem_ready) m_active = 1'b0;
                else begin
                    m_low++;
                    if (m_low == TIMEOUT) begin m_err = 1'b1; m_active = 1'b0; end
                end
            end else if (exp_freeze()) begin
                m_active = 1'b1;
                m_low    = 1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0; memreadE = 0; branch_takenE = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        set_idle();
        @(posedge clk);
        #1;
        m_active = 0; m_low = 0; m_err = 0; m_cnt = 0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_idle();
        mem_req = 1; branch_takenE = 1; rdM = 3; regwriteM = 1; rs1E = 3;
        #2;
        tests++;
        if (dut_vec !== 16'hf800) begin
            fails++;
            $display("FAIL reset_outputs: got %h want %h", dut_vec, 16'hf800);
        end
        apply_reset();
        #1;
        tests++;
        if (dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL reset_idle: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_lwstall();
        apply_reset();
        rdE = 5; memreadE = 1; regwriteE = 1; rs1D = 5;
        #1;
        tests++;
        if ({en_vec, clearD, clearE} !== 7'b0011101 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL lwstall_bubble: got en=%b cd=%b ce=%b want en=00111 cd=0 ce=1",
                     en_vec, clearD, clearE);
        end
        tick();
        memreadE = 0; regwriteE = 0; rdE = 0;
        #1;
        tests++;
        if ({en_vec, clearE, stall_cnt} !== {5'h1f, 1'b0, 4'd1}) begin
            fails++;
            $display("FAIL lwstall_resume: got en=%b ce=%b cnt=%0d want en=11111 ce=0 cnt=1",
                     en_vec, clearE, stall_cnt);
        end
        rdE = 0; memreadE = 1; regwriteE = 1; rs1D = 0;
        #1;
        tests++;
        if ({en_vec, clearE} !== 6'b111110) begin
            fails++;
            $display("FAIL lwstall_rd0: got en=%b ce=%b want en=11111 ce=0", en_vec, clearE);
        end
    endtask

    task automatic test_branch_over_lw();
        apply_reset();
        rdE = 7; memreadE = 1; regwriteE = 1; rs2D = 7; branch_takenE = 1;
        #1;
        tests++;
        if ({en_vec, clearD, clearE} !== 7'b1111111) begin
            fails++;
            $display("FAIL branch_lw: got en=%b cd=%b ce=%b want all 1", en_vec, clearD, clearE);
        end
        tick();
        set_idle();
        #1;
        tests++;
        if (stall_cnt !== 4'd0) begin
            fails++;
            $display("FAIL branch_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_forward();
        apply_reset();
        rdM = 3; rdW = 3; regwriteM = 1; regwriteW = 1; rs1E = 3; rs2E = 4;
        #1;
        tests++;
        if (forwardAE !== 2'b10 || forwardBE !== 2'b00) begin
            fails++;
            $display("FAIL fwd_m_prio: got A=%b B=%b want A=10 B=00", forwardAE, forwardBE);
        end
        regwriteM = 0; rs2E = 3;
        #1;
        tests++;
        if (forwardAE !== 2'b01 || forwardBE !== 2'b01) begin
            fails++;
            $display("FAIL fwd_w: got A=%b B=%b want A=01 B=01", forwardAE, forwardBE);
        end
        rdW = 0; rs1E = 0; rs2E = 0;
        #1;
        tests++;
        if (forwardAE !== 2'b00 || forwardBE !== 2'b00) begin
            fails++;
            $display("FAIL fwd_r0: got A=%b B=%b want 00", forwardAE, forwardBE);
        end
    endtask

    task automatic test_memwait();
        int frozen;
        apply_reset();
        frozen = 0;
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (en_vec === 5'h00) frozen++;
            tick();
        end
        mem_ready = 1;
        #1;
        if (en_vec === 5'h00) frozen++;
        tests++;
        if (frozen !== 4) begin
            fails++;
            $display("FAIL memwait_frozen: got %0d frozen cycles want 4", frozen);
        end
        tick();
        mem_req = 0; mem_ready = 0;
        #1;
        tests++;
        if (stall_cnt !== 4'd4 || en_vec !== 5'h1f || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL memwait_release: got cnt=%0d en=%b want cnt=4 en=11111",
                     stall_cnt, en_vec);
        end
    endtask

    task automatic test_timeout();
        int early_err;
        apply_reset();
        early_err = 0;
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            if (mem_err !== 1'b0) early_err++;
            tick();
        end
        tests++;
        if (early_err !== 0) begin
            fails++;
            $display("FAIL timeout_early: mem_err high in %0d cycles want 0", early_err);
        end
        mem_req = 0;
        #1;
        tests++;
        if (mem_err !== 1'b1 || en_vec !== 5'h00 || dut_vec !== exp_vec()) begin
            fails++;
            $display("FAIL timeout_err: got err=%b en=%b want err=1 en=00000", mem_err, en_vec);
        end
        reset = 0;
        #1;
        tests++;
        if (mem_err !== 1'b0 || en_vec !== 5'h1f) begin
            fails++;
            $display("FAIL timeout_reset: got err=%b en=%b want err=0 en=11111", mem_err, en_vec);
        end
        apply_reset();
    endtask

    task automatic test_reset_midwait();
        apply_reset();
        mem_req = 1; mem_ready = 0;
        repeat (3) tick();
        reset = 0;
        #1;
        tests++;
        if (dut_vec !== 16'hf800) begin
            fails++;
            $display("FAIL midwait_reset: got %h want %h", dut_vec, 16'hf800);
        end
        apply_reset();
        #1;
        tests++;
        if (dut_vec !== exp_vec() || stall_cnt !== 4'd0) begin
            fails++;
            $display("FAIL midwait_after: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        rdE = 9; memreadE = 1; regwriteE = 1; rs1D = 9;
        repeat (20) tick();
        #1;
        tests++;
        if (stall_cnt !== 4'hf) begin
            fails++;
            $display("FAIL stall_sat: got %0d want 15", stall_cnt);
        end
    endtask

    task automatic test_random();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            rs1D = REGW'($urandom_range(0, 3)); rs2D = REGW'($urandom_range(0, 3));
            rs1E = REGW'($urandom_range(0, 3)); rs2E = REGW'($urandom_range(0, 3));
            rdE  = REGW'($urandom_range(0, 3)); rdM  = REGW'($urandom_range(0, 3));
            rdW  = REGW'($urandom_range(0, 3));
            regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
            memreadE  = 1'($urandom);
            branch_takenE = ($urandom_range(0, 5) == 0);
            mem_req   = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            if (i % 100 == 99) begin
                apply_reset();
                continue;
            end
            #1;
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_cycle %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        test_reset();
        test_lwstall();
        test_branch_over_lw();
        test_forward();
        test_memwait();
        test_timeout();
        test_reset_midwait();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
